fsk16_zc_demod: RTL and testbench
=================================

# fsk16_zc_demod

Receive-side 16-FSK symbol demodulator for the FSK modulator/demodulator datapath. It takes signed ADC samples of the received tone, detects rising zero crossings through a hysteresis comparator, and counts them over a fixed symbol window. At the end of each window it maps the count to a 4-bit symbol and strobes it out. It is the receive counterpart of the 16-FSK modulator, which emits tone k as exactly BASE_CNT + STEP_CNT·k full cycles per symbol window.

## Interface
- ADC_W, 12, signed sample width
- HYST, 64, hysteresis threshold magnitude in LSBs (positive)
- SYM_CYCLES, 400, clock cycles (samples) per symbol window; must be ≥ 2
- BASE_CNT, 4, crossing count expected for symbol 0
- STEP_CNT, 2, crossing-count increment per symbol; must be a power of two ≥ 1

Ports:
- clk  in  1  system clock, one ADC sample per cycle
- reset  in  1  synchronous, active-low reset
- adc_in  in  ADC_W  signed two's-complement sample
- sym_start  in  1  window realignment pulse
- data_out  out  4  decided symbol
- data_valid  out  1  one-cycle strobe, data_out is new
- sym_err  out  1  last decided symbol was clamped; updates with data_valid
- err_cnt  out  16  saturating count of clamped symbols

## Operation
- Comparator FSM, with states UNK, NEG and POS:
  - UNK → NEG when adc_in ≤ −HYST. UNK ignores the +HYST threshold.
  - NEG → POS when adc_in ≥ +HYST. This transition is one rising crossing.
  - POS → NEG when adc_in ≤ −HYST.
  - Otherwise the state holds. Comparisons are signed.
- The comparator state persists across window boundaries and sym_start. Only reset returns it to UNK.
- Window counter `wcnt` runs 0..SYM_CYCLES−1 and wraps. Crossing counter `C` is $clog2(SYM_CYCLES)+1 bits wide and cannot overflow, because hysteresis limits it to at most SYM_CYCLES/2.
- End of window (wcnt == SYM_CYCLES−1, no sym_start):
  - Final count C' = C + crossing from this cycle's sample.
  - If C' < BASE_CNT: symbol 0, sym_err = 1.
  - Otherwise s = (C' − BASE_CNT + STEP_CNT/2) >> log2(STEP_CNT). When STEP_CNT = 1 the rounding term is 0.
  - If s > 15: symbol 15, sym_err = 1. Otherwise symbol s, sym_err = 0.
  - Register data_out and sym_err, pulse data_valid, clear C.
- sym_start = 1: wcnt and C restart, and the in-progress window is discarded with no data_valid. This holds even when wcnt == SYM_CYCLES−1. The current cycle's sample counts as index 0 of the new window.
- data_out and sym_err hold their values between strobes.

## Timing
- reset low at a clk edge puts every register in its reset state: data_out 0, data_valid 0, sym_err 0, err_cnt 0, wcnt 0, C 0, comparator UNK. This applies mid-window too, and the partial window is discarded.
- After reset is released, the first window starts on the first edge with reset high.
- data_valid goes high in the cycle after the edge that samples window index SYM_CYCLES−1. It is high for exactly 1 cycle, once every SYM_CYCLES cycles when no sym_start occurs.
- Latency is 1 cycle from the last sample of a window to data_out.
- A crossing on the final sample of a window counts in that window.
- A crossing in a sym_start cycle counts in the new window.

## Configuration
- `FSK_DEMOD_ERRCNT_EN` defined:
  - err_cnt increments by 1 on each data_valid where sym_err = 1.
  - It saturates at 16'hFFFF and clears only on reset.
- Not defined:
  - err_cnt is tied to 16'h0000 and no counter logic is generated.
  - sym_err behaves as specified in both builds.

## Test plan
- Reset low for 20 cycles with a full-scale tone on adc_in → data_out 0, data_valid 0, sym_err 0, err_cnt 0 throughout.
- sym_start pulse, then a 14-cycle/400-sample sine of amplitude 1000 → data_valid exactly 400 cycles later with data_out = 5 and sym_err 0.
- Back-to-back windows, tone k = 0..15 (4 + 2k cycles/window), repeated 3 times → data_out sequence 0..15 ×3, one data_valid every 400 cycles, no sym_err.
- Tone k = 9 plus uniform noise ±50, then a window of noise alone (no crossings):
  - The tone window gives data_out 9.
  - The noise-only window gives data_out 0 and sym_err 1.
  - err_cnt reads 1 with the macro defined and 0 without it.
- 40 cycles/window tone → data_out 15, sym_err 1.
- sym_start asserted at wcnt 150 → no strobe for the truncated window; the next data_valid comes 400 cycles after that sym_start. Separately, reset low at wcnt 200 → outputs return to 0, and the first strobe after release comes 400 cycles later.

Source files
------------

// File: rtl/fsk16_zc_demod.sv
// 16-FSK zero-crossing demodulator: hysteresis comparator, per-window rising-crossing count, count-to-symbol decision.
// Optional saturating clamped-symbol counter on err_cnt when FSK_DEMOD_ERRCNT_EN is defined.
module fsk16_zc_demod #(
  parameter int ADC_W      = 12,
  parameter int HYST       = 64,
  parameter int SYM_CYCLES = 400,
  parameter int BASE_CNT   = 4,
  parameter int STEP_CNT   = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [ADC_W-1:0] adc_in,
  input  logic                    sym_start,
  output logic [3:0]              data_out,
  output logic                    data_valid,
  output logic                    sym_err,
  output logic [15:0]             err_cnt
);

  localparam int WCNT_W  = $clog2(SYM_CYCLES);
  localparam int CNT_W   = WCNT_W + 1;
  localparam int STEP_SH = $clog2(STEP_CNT);
  localparam logic signed [ADC_W-1:0] POS_TH = ADC_W'(HYST);
  localparam logic signed [ADC_W-1:0] NEG_TH = ADC_W'(-HYST);

  typedef enum logic [1:0] {CMP_UNK, CMP_NEG, CMP_POS} cmp_t;

  // Returns {clamped, symbol}; rounds the count to the nearest symbol step.
  function automatic logic [4:0] decide(input logic [CNT_W-1:0] c);
    logic [31:0] cw;
    logic [31:0] s;
    cw = 32'(c);
    if (cw < 32'(BASE_CNT)) return 5'b1_0000;
    s = (cw - 32'(BASE_CNT) + 32'(STEP_CNT / 2)) >> STEP_SH;
    if (s > 32'd15) return 5'b1_1111;
    return {1'b0, s[3:0]};
  endfunction

  cmp_t              r_cmp;
  cmp_t              w_cmp_nxt;
  logic              w_cross;
  logic              w_ge_pos;
  logic              w_le_neg;
  logic [WCNT_W-1:0] r_wcnt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_fin;
  logic              w_last;
  logic              w_eow;
  logic [4:0]        w_dec;
  logic [3:0]        r_data;
  logic              r_valid;
  logic              r_err;

  assign w_ge_pos = (adc_in >= POS_TH);
  assign w_le_neg = (adc_in <= NEG_TH);

  always_ff @(posedge clk) begin
    if (!reset) r_cmp <= CMP_UNK;
    else        r_cmp <= w_cmp_nxt;
  end

  // Only a NEG->POS transition is a rising crossing; UNK must see a negative level first.
  always_comb begin
    w_cmp_nxt = r_cmp;
    w_cross   = 1'b0;
    case (r_cmp)
      CMP_UNK: if (w_le_neg) w_cmp_nxt = CMP_NEG;
      CMP_NEG: if (w_ge_pos) begin
        w_cmp_nxt = CMP_POS;
        w_cross   = 1'b1;
      end
      CMP_POS: if (w_le_neg) w_cmp_nxt = CMP_NEG;
      default: w_cmp_nxt = CMP_UNK;
    endcase
  end

  assign w_last    = (r_wcnt == WCNT_W'(SYM_CYCLES - 1));
  assign w_eow     = w_last && !sym_start;
  assign w_cnt_fin = r_cnt + CNT_W'(w_cross);
  assign w_dec     = decide(w_cnt_fin);

  // sym_start makes the current sample index 0, so the counter resumes at 1.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wcnt  <= '0;
      r_cnt   <= '0;
      r_data  <= 4'd0;
      r_err   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_eow;
      if (sym_start) begin
        r_wcnt <= WCNT_W'(1);
        r_cnt  <= CNT_W'(w_cross);
      end else if (w_last) begin
        r_wcnt <= '0;
        r_cnt  <= '0;
        r_data <= w_dec[3:0];
        r_err  <= w_dec[4];
      end else begin
        r_wcnt <= r_wcnt + WCNT_W'(1);
        r_cnt  <= w_cnt_fin;
      end
    end
  end

  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign sym_err    = r_err;

`ifdef FSK_DEMOD_ERRCNT_EN
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (!reset)
      r_err_cnt <= 16'h0000;
    else if (w_eow && w_dec[4] && (r_err_cnt != 16'hFFFF))
      r_err_cnt <= r_err_cnt + 16'h0001;
  end

  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fsk16_zc_demod.sv
// Scoreboard bench for fsk16_zc_demod: stimulus queues expected strobes, a negedge monitor checks them.
module tb_fsk16_zc_demod;

  localparam int ADC_W = 12;
  localparam int SYM   = 400;
`ifdef FSK_DEMOD_ERRCNT_EN
  localparam int EXP_ERRS = 1;
`else
  localparam int EXP_ERRS = 0;
`endif

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic signed [ADC_W-1:0] adc_in = '0;
  logic                    sym_start = 1'b0;
  logic [3:0]              data_out;
  logic                    data_valid;
  logic                    sym_err;
  logic [15:0]             err_cnt;

  fsk16_zc_demod dut (
    .clk        (clk),
    .reset      (reset),
    .adc_in     (adc_in),
    .sym_start  (sym_start),
    .data_out   (data_out),
    .data_valid (data_valid),
    .sym_err    (sym_err),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] d;
    logic       e;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_strobe cyc=%0d data_out=%0d sym_err=%0d, no strobe expected", cyc, data_out, sym_err);
      end else begin
        m_e = q.pop_front();
        if (data_out !== m_e.d || sym_err !== m_e.e || cyc != m_e.cyc) begin
          n_err++;
          $display("FAIL strobe got data=%0d err=%0d cyc=%0d, want data=%0d err=%0d cyc=%0d",
                   data_out, sym_err, cyc, m_e.d, m_e.e, m_e.cyc);
        end
      end
    end
  end

  function automatic int tone(input int f, input int n, input int amp);
    real ph;
    ph = 2.0 * 3.14159265358979 * real'(f) * real'(n) / real'(SYM);
    return $rtoi($floor(real'(amp) * $sin(ph) + 0.5));
  endfunction

  task automatic step(input int s, input logic ss, input logic rst);
    @(negedge clk);
    adc_in    = ADC_W'(s);
    sym_start = ss;
    reset     = rst;
  endtask

  task automatic chk(input string nm, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_data_out"}, int'(data_out), 0);
    chk({nm, "_valid"}, int'(data_valid), 0);
    chk({nm, "_sym_err"}, int'(sym_err), 0);
    chk({nm, "_err_cnt"}, int'(err_cnt), 0);
  endtask

  // Drives nsamp samples of an f-cycle tone; the strobe is expected one edge after sample SYM-1.
  task automatic window(input int f, input int amp, input int nz, input logic ss,
                        input int nsamp, input logic push, input logic [3:0] ed, input logic ee);
    exp_t e;
    for (int n = 0; n < nsamp; n++) begin
      int s;
      s = tone(f, n, amp);
      if (nz > 0) s += int'($urandom_range(2 * nz)) - nz;
      step(s, ss && (n == 0), 1'b1);
      if (push && n == SYM - 1) begin
        e.cyc = cyc + 1;
        e.d   = ed;
        e.e   = ee;
        q.push_back(e);
      end
    end
  endtask

  initial begin
    // Reset held with a full-scale tone present.
    for (int i = 0; i < 20; i++) begin
      step(tone(14, i, 2047), 1'b0, 1'b0);
      chk_zero("reset_hold");
    end

    // 14 cycles/window after a sym_start -> symbol 5.
    window(14, 1000, 0, 1'b1, SYM, 1'b1, 4'd5, 1'b0);

    // Back-to-back tones 0..15, three passes.
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 16; k++)
        window(4 + 2 * k, 1000, 0, 1'b0, SYM, 1'b1, 4'(k), 1'b0);

    // Noisy tone 9, then noise alone.
    window(22, 1000, 50, 1'b0, SYM, 1'b1, 4'd9, 1'b0);
    window(0, 0, 50, 1'b0, SYM, 1'b1, 4'd0, 1'b1);
    step(0, 1'b0, 1'b1);
    chk("err_cnt_noise", int'(err_cnt), EXP_ERRS);

    // 40 cycles/window clamps to 15.
    window(40, 1000, 0, 1'b1, SYM, 1'b1, 4'd15, 1'b1);
    step(0, 1'b0, 1'b1);
    chk("err_cnt_clamp", int'(err_cnt), 2 * EXP_ERRS);

    // sym_start at wcnt 150 truncates the window; next strobe 400 cycles later.
    window(14, 1000, 0, 1'b1, 150, 1'b0, 4'd0, 1'b0);
    window(10, 1000, 0, 1'b1, SYM, 1'b1, 4'd3, 1'b0);

    // Reset at wcnt 200 discards the window and clears the outputs.
    window(18, 1000, 0, 1'b1, 200, 1'b0, 4'd0, 1'b0);
    step(0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1'b0, 1'b0);
      chk_zero("reset_mid");
    end
    window(8, 1000, 0, 1'b0, SYM, 1'b1, 4'd2, 1'b0);

    step(0, 1'b0, 1'b1);
    step(0, 1'b0, 1'b1);
    chk("queue_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
